// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: steps an external 1-bit fullsub
// cell LSB first and wraps the result in a start/busy/done handshake.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_c,
  input  logic             fs_x,
  input  logic             fs_y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    fs_a     = 1'b0;
    fs_b     = 1'b0;
    fs_c     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        fs_a = a_sh[0];
        fs_b = b_sh[0];
        fs_c = brw;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The last bit's difference and borrow come straight from the cell on the
  // final RUN edge, so diff/bout capture them directly rather than via res_sh.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          res_sh <= {fs_x, res_sh[WIDTH-1:1]};
          brw    <= fs_y;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff <= {fs_x, res_sh[WIDTH-1:1]};
            bout <= fs_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl with a behavioural fullsub cell;
// expected results are queued on accept and popped when done pulses.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         fs_a;
  logic         fs_b;
  logic         fs_c;
  logic         fs_x;
  logic         fs_y;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout),
    .fs_a(fs_a), .fs_b(fs_b), .fs_c(fs_c), .fs_x(fs_x), .fs_y(fs_y)
  );

  // external full-subtractor cell
  assign fs_x = fs_a ^ fs_b ^ fs_c;
  assign fs_y = (~fs_a & fs_b) | (~fs_a & fs_c) | (fs_b & fs_c);

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
  endfunction

  // Drives one accepted request (caller is at a negedge with ready=1) and
  // scrambles the operand inputs afterwards.
  task automatic issue(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
    a     = na;
    b     = nb;
    bin   = nbin;
    start = 1'b1;
    exp_q.push_back(model(na, nb, nbin));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cycles < 50) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 100", {ready, busy, done});
    end
    checks++;
    if ({bout, diff} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result got %h expected 000", {bout, diff});
    end
    checks++;
    if ({fs_a, fs_b, fs_c} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_fs got %b expected 000", {fs_a, fs_b, fs_c});
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[5] = '{8'd5, 8'd3, 8'd0, 8'hFF, 8'h80};
    logic [W-1:0] vb[5] = '{8'd3, 8'd5, 8'd0, 8'hFF, 8'h01};
    logic         vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W:0]   ve[5] = '{9'h002, 9'h1FE, 9'h1FF, 9'h000, 9'h07E};
    int cycles;
    bit busy_ok;
    logic [W:0] e;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(cycles, busy_ok);
      e = exp_q.pop_front();
      checks++;
      if (cycles !== 8) begin
        errors++;
        $display("[TB] FAIL vec%0d_latency got %0d expected 8", i, cycles);
      end
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("[TB] FAIL vec%0d_busy got 0 expected 1 throughout RUN", i);
      end
      checks++;
      if ({bout, diff} !== ve[i] || e !== ve[i]) begin
        errors++;
        $display("[TB] FAIL vec%0d_result got %h expected %h", i, {bout, diff}, ve[i]);
      end
      @(negedge clk);
      checks++;
      if ({done, ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL vec%0d_done_pulse got done,ready=%b expected 01", i, {done, ready});
      end
    end
  endtask

  task automatic test_start_during_run();
    int cycles;
    bit busy_ok;
    logic [W:0] e;
    issue(8'h40, 8'h11, 1'b0);
    a     = 8'h01;
    b     = 8'hF0;
    bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sdr_busy got %b expected 1", busy);
    end
    wait_done(cycles, busy_ok);
    e = exp_q.pop_front();
    checks++;
    if (cycles !== 7 || !busy_ok) begin
      errors++;
      $display("[TB] FAIL sdr_timing got cycles=%0d busy_ok=%0d expected 7,1", cycles, busy_ok);
    end
    checks++;
    if ({bout, diff} !== e) begin
      errors++;
      $display("[TB] FAIL sdr_result got %h expected %h", {bout, diff}, e);
    end
    @(negedge clk);
    checks++;
    if ({ready, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL sdr_idle got ready,busy=%b expected 10", {ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit busy_ok;
    logic [W:0] e;
    a     = 8'h9C;
    b     = 8'h2D;
    bin   = 1'b1;
    start = 1'b1;
    exp_q.push_back(model(8'h9C, 8'h2D, 1'b1));
    @(negedge clk);
    a   = 8'h12;
    b   = 8'h34;
    bin = 1'b0;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    wait_done(cycles, busy_ok);
    e = exp_q.pop_front();
    checks++;
    if ({bout, diff} !== e || cycles !== 8) begin
      errors++;
      $display("[TB] FAIL b2b_first got %h cycles=%0d expected %h cycles=8", {bout, diff}, cycles, e);
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_reaccept got busy=%b expected 1", busy);
    end
    wait_done(cycles, busy_ok);
    e = exp_q.pop_front();
    checks++;
    if ({bout, diff} !== e || cycles !== 8) begin
      errors++;
      $display("[TB] FAIL b2b_second got %h cycles=%0d expected %h cycles=8", {bout, diff}, cycles, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    bit busy_ok;
    bit saw_done;
    logic [W:0] e;
    issue(8'hA5, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL rmr_flags got %b expected 100", {ready, busy, done});
    end
    checks++;
    if ({bout, diff} !== '0) begin
      errors++;
      $display("[TB] FAIL rmr_result got %h expected 000", {bout, diff});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL rmr_no_done got done pulse expected none");
    end
    issue(8'h37, 8'h58, 1'b1);
    wait_done(cycles, busy_ok);
    e = exp_q.pop_front();
    checks++;
    if ({bout, diff} !== e || cycles !== 8) begin
      errors++;
      $display("[TB] FAIL rmr_after got %h cycles=%0d expected %h cycles=8", {bout, diff}, cycles, e);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cycles;
    bit busy_ok;
    logic [W:0] e;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rnd%0d_ready got %b expected 1", n, ready);
      end
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done(cycles, busy_ok);
      e = exp_q.pop_front();
      checks++;
      if ({bout, diff} !== e || cycles !== 8 || !busy_ok) begin
        errors++;
        $display("[TB] FAIL rnd%0d_result got %h cycles=%0d busy_ok=%0d expected %h cycles=8 busy_ok=1",
                 n, {bout, diff}, cycles, busy_ok, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
